ddr_cmd_encoder: RTL and testbench
==================================

// Module: ddr_cmd_encoder
// PURPOSE
// - Sits directly downstream of the controller init sequencer.
// - Converts its one-hot strobes (des_rdy / mrs_rdy / zqcl_rdy + mode_reg) into the registered DDR4 command/address bus.
// - Keeps shadow copies of MR0..MR6 and decodes the timing fields.
// - Runs a protocol-timing monitor (tMRD, tMOD, tZQinit) and raises init_ok once the bring-up sequence is complete and legal.
// PARAMETERS
// MR_W   21   mode_reg width: [20:18]=MR select {BG0,BA1,BA0}, [17:0]=A17..A0
// TMRD   8    min cycles between MRS commands (CK_t cycles)
// TMOD   24   min cycles from last MRS to next non-DES/non-MRS command
// TZQ    1024 cycles after ZQCL during which only DES is legal
// PORTS
// CK_t       in   1     system clock, all logic on posedge
// reset      in   1     synchronous, active-high
// des_rdy    in   1     issue DES this cycle
// mrs_rdy    in   1     issue MRS with mode_reg this cycle
// zqcl_rdy   in   1     issue ZQCL this cycle
// mode_reg   in   MR_W  MR select + A17..A0 payload; only sampled with mrs_rdy
// ini_done   in   1     init sequencer finished
// CS_n       out  1     chip select
// ACT_n      out  1     activate
// RAS_n_A16  out  1     RAS_n / A16
// CAS_n_A15  out  1     CAS_n / A15
// WE_n_A14   out  1     WE_n / A14
// BG         out  2     bank group
// BA         out  2     bank address
// A          out  14    A13..A0
// mr_loaded  out  7     bit i set once MRi written since reset
// cl_code    out  4     MR0 {A6:A4,A2}
// bl_code    out  2     MR0 A1:A0
// al_code    out  2     MR1 A4:A3
// cwl_code   out  3     MR2 A5:A3
// wr_pre     out  1     MR4 A12
// rd_pre     out  1     MR4 A11
// timing_err out  3     sticky {tzq_err, tmod_err, tmrd_err}
// proto_err  out  1     sticky: more than one *_rdy high in one cycle
// init_ok    out  1     level
// BEHAVIOUR
// - Reset (sync, one edge): CS_n=1; ACT_n=1; RAS/CAS/WE=1; BG/BA/A=0; mr_loaded=0; all *_code and pre bits=0; errors=0; init_ok=0; FSM=S_PRE.
// - Latency: strobes sampled at posedge N, bus driven from posedge N+1. Each command is held exactly one cycle.
// - Encoding (CS,ACT,RAS,CAS,WE):
//   - MRS = 0,1,0,0,0; BG={1'b0,mode_reg[20]}, BA=mode_reg[19:18], A=mode_reg[13:0].
//   - ZQCL = 0,1,1,1,0; A10=1, rest 0.
//   - DES and no-strobe cycles = CS_n=1, other outputs unchanged-don't-care, driven 0.
// - Simultaneous strobes: priority mrs > zqcl > des. Only the winner is encoded; proto_err sets (sticky).
// - MRS with MR select 7 (MR7/RFU): encoded on the bus; no shadow update.
// - MRS with MR select 0..6: shadow MRi <= mode_reg[17:0] and mr_loaded[i] <= 1. Decoded outputs update in the same cycle as the bus.
// - Monitor counter: gap_cnt, width $clog2(TZQ+1), saturating. Cleared on each MRS/ZQCL, otherwise +1 per cycle.
// - FSM states:
//   - S_PRE: first MRS -> S_MRS.
//   - S_MRS:
//     - MRS with gap_cnt < TMRD-1 -> tmrd_err.
//     - ZQCL with gap_cnt < TMOD-1 -> tmod_err.
//     - ZQCL -> S_ZQ.
//   - S_ZQ:
//     - Any MRS/ZQCL while gap_cnt < TZQ-1 -> tzq_err.
//     - ini_done -> S_DONE.
//   - S_DONE: absorbing until reset.
// - init_ok = (state==S_DONE) && mr_loaded==7'h7F && timing_err==0 && !proto_err. It drops if an error later sets.
// - ini_done seen in S_PRE or S_MRS: go to S_DONE, init_ok stays 0 (mr_loaded or ZQ incomplete); tmod_err sets.
// - Reset mid-sequence: everything returns to reset values on that edge; the strobe sampled in the same cycle is ignored.
// STRUCTURE
// - Shared package ddr_pkg: cmd_t enum {CMD_DES,CMD_NOP,CMD_MRS,CMD_ZQCL}, struct ddr_cmd_bus_t, MR_W, and the tMRD/tMOD/tZQ constants used as parameter defaults.
// - One sub-module: ddr_timing_mon (gap counter + FSM + error flags).
// - Encoder and shadow registers live in the top.
// TESTING
// - Reset held 3 cycles, then released -> CS_n=1, init_ok=0, mr_loaded=0, timing_err=0.
// - mrs_rdy with mode_reg={3'b000,18'h00D34} at edge N -> edge N+1: CS_n=0, ACT_n=1, RAS/CAS/WE=0, BA=0, A=14'h0D34; cl_code and bl_code decoded; mr_loaded=7'h01.
// - Full legal sequence MR3,6,5,4,2,1,0 spaced TMRD, TMOD gap, ZQCL, TZQ DES, ini_done -> init_ok=1, timing_err=0.
// - Two MRS spaced 3 cycles (TMRD=8) -> timing_err[0]=1 sticky; init_ok stays 0 after ini_done.
// - mrs_rdy and zqcl_rdy high together -> MRS encoded, proto_err=1.
// - Reset asserted between MR4 and MR2 -> mr_loaded=0, FSM S_PRE; a restarted legal sequence reaches init_ok=1.

Source files
------------

// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Shared types and constants for the DDR4 init command encoder.
//   cmd_t          : command selected for the current cycle
//   ddr_cmd_bus_t  : registered command/address pin bundle
//   MR_W           : mode_reg width ({BG0,BA1,BA0} select + A17..A0)
//   TMRD_DEF/TMOD_DEF/TZQ_DEF : default protocol timings in CK_t cycles
//   encode_cmd()   : maps a command plus MR select/address onto the pins
// ---------------------------------------------------------------------------
package ddr_pkg;

  localparam int MR_W     = 21;
  localparam int TMRD_DEF = 8;
  localparam int TMOD_DEF = 24;
  localparam int TZQ_DEF  = 1024;

  typedef enum logic [1:0] {
    CMD_DES,
    CMD_NOP,
    CMD_MRS,
    CMD_ZQCL
  } cmd_t;

  typedef struct packed {
    logic        cs_n;
    logic        act_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] a;
  } ddr_cmd_bus_t;

  localparam ddr_cmd_bus_t BUS_RESET = '{
    cs_n: 1'b1, act_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
    bg: 2'b00, ba: 2'b00, a: 14'h0000
  };

  // Deselect cycles only need CS_n high; every other pin is parked at 0.
  function automatic ddr_cmd_bus_t encode_cmd(input cmd_t        cmd,
                                              input logic [2:0]  sel,
                                              input logic [13:0] addr);
    ddr_cmd_bus_t bus;
    bus      = '0;
    bus.cs_n = 1'b1;
    case (cmd)
      CMD_MRS: begin
        bus.cs_n  = 1'b0;
        bus.act_n = 1'b1;
        bus.bg    = {1'b0, sel[2]};
        bus.ba    = sel[1:0];
        bus.a     = addr;
      end
      CMD_ZQCL: begin
        bus.cs_n  = 1'b0;
        bus.act_n = 1'b1;
        bus.ras_n = 1'b1;
        bus.cas_n = 1'b1;
        bus.a     = 14'h0400;  // A10 high selects ZQ long calibration
      end
      default: ;
    endcase
    return bus;
  endfunction

endpackage

// File: rtl/ddr_cmd_encoder_timing_mon.sv
// ---------------------------------------------------------------------------
// ddr_timing_mon
// Protocol timing monitor for the init sequence: a saturating gap counter
// since the last MRS/ZQCL, the bring-up FSM and the sticky timing errors.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   cmd_i          : command selected this cycle (after strobe priority)
//   ini_done_i     : init sequencer reports completion
//   done_o         : FSM has reached S_DONE
//   timing_err_o   : sticky {tzq_err, tmod_err, tmrd_err}
// ---------------------------------------------------------------------------
module ddr_timing_mon
  import ddr_pkg::*;
#(
  parameter int TMRD = TMRD_DEF,
  parameter int TMOD = TMOD_DEF,
  parameter int TZQ  = TZQ_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  cmd_t       cmd_i,
  input  logic       ini_done_i,
  output logic       done_o,
  output logic [2:0] timing_err_o
);

  localparam int GW = $clog2(TZQ + 1);
  localparam logic [GW-1:0] TMRD_LIM = GW'(TMRD - 1);
  localparam logic [GW-1:0] TMOD_LIM = GW'(TMOD - 1);
  localparam logic [GW-1:0] TZQ_LIM  = GW'(TZQ - 1);

  typedef enum logic [1:0] {S_PRE, S_MRS, S_ZQ, S_DONE} state_t;

  state_t        state_q;
  logic [GW-1:0] gap_q;
  logic          done_q;
  logic          tmrd_err_q;
  logic          tmod_err_q;
  logic          tzq_err_q;

  logic is_mrs;
  logic is_zq;
  logic is_cmd;

  assign is_mrs = (cmd_i == CMD_MRS);
  assign is_zq  = (cmd_i == CMD_ZQCL);
  assign is_cmd = is_mrs | is_zq;

  // gap_q counts cycles since the last MRS/ZQCL edge (0 on the cycle right
  // after it), so a gap of N cycles between commands reads as N-1 here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_PRE;
      gap_q      <= '0;
      done_q     <= 1'b0;
      tmrd_err_q <= 1'b0;
      tmod_err_q <= 1'b0;
      tzq_err_q  <= 1'b0;
    end else begin
      if (is_cmd)
        gap_q <= '0;
      else if (gap_q != '1)
        gap_q <= gap_q + GW'(1);

      case (state_q)
        S_PRE: begin
          // Finishing before any MRS means the MR/ZQ flow was skipped.
          if (ini_done_i) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            tmod_err_q <= 1'b1;
          end else if (is_mrs) begin
            state_q <= S_MRS;
          end
        end
        S_MRS: begin
          if (is_mrs && (gap_q < TMRD_LIM))
            tmrd_err_q <= 1'b1;
          if (is_zq && (gap_q < TMOD_LIM))
            tmod_err_q <= 1'b1;
          if (ini_done_i) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            tmod_err_q <= 1'b1;
          end else if (is_zq) begin
            state_q <= S_ZQ;
          end
        end
        S_ZQ: begin
          if (is_cmd && (gap_q < TZQ_LIM))
            tzq_err_q <= 1'b1;
          if (ini_done_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: ;  // S_DONE holds until reset
      endcase
    end
  end

  assign done_o       = done_q;
  assign timing_err_o = {tzq_err_q, tmod_err_q, tmrd_err_q};

endmodule

// File: rtl/ddr_cmd_encoder.sv
// ---------------------------------------------------------------------------
// ddr_cmd_encoder
// Turns the init sequencer's one-hot strobes into the registered DDR4
// command/address bus, shadows MR0..MR6, decodes the timing fields and
// reports whether bring-up completed legally.
//   CK_t, reset                  : clock, synchronous active-high reset
//   des_rdy/mrs_rdy/zqcl_rdy     : command strobes (priority mrs>zqcl>des)
//   mode_reg[MR_W-1:0]           : {BG0,BA1,BA0} MR select + A17..A0
//   ini_done                     : init sequencer finished
//   CS_n,ACT_n,RAS_n_A16,CAS_n_A15,WE_n_A14,BG,BA,A : command bus
//   mr_loaded                    : bit i set once MRi has been written
//   cl_code,bl_code,al_code,cwl_code,wr_pre,rd_pre : decoded MR fields
//   timing_err                   : sticky {tzq_err, tmod_err, tmrd_err}
//   proto_err                    : sticky, more than one strobe in a cycle
//   init_ok                      : bring-up complete and legal
// ---------------------------------------------------------------------------
module ddr_cmd_encoder #(
  parameter int MR_W = ddr_pkg::MR_W,
  parameter int TMRD = ddr_pkg::TMRD_DEF,
  parameter int TMOD = ddr_pkg::TMOD_DEF,
  parameter int TZQ  = ddr_pkg::TZQ_DEF
) (
  input  logic            CK_t,
  input  logic            reset,
  input  logic            des_rdy,
  input  logic            mrs_rdy,
  input  logic            zqcl_rdy,
  input  logic [MR_W-1:0] mode_reg,
  input  logic            ini_done,
  output logic            CS_n,
  output logic            ACT_n,
  output logic            RAS_n_A16,
  output logic            CAS_n_A15,
  output logic            WE_n_A14,
  output logic [1:0]      BG,
  output logic [1:0]      BA,
  output logic [13:0]     A,
  output logic [6:0]      mr_loaded,
  output logic [3:0]      cl_code,
  output logic [1:0]      bl_code,
  output logic [1:0]      al_code,
  output logic [2:0]      cwl_code,
  output logic            wr_pre,
  output logic            rd_pre,
  output logic [2:0]      timing_err,
  output logic            proto_err,
  output logic            init_ok
);

  import ddr_pkg::*;

  localparam int SEL_LSB = MR_W - 3;

  cmd_t         cmd_d;
  logic         proto_d;
  logic [2:0]   mr_sel;
  ddr_cmd_bus_t bus_q;
  logic [17:0]  mr_q [7];
  logic [6:0]   mr_loaded_q;
  logic         proto_err_q;
  logic         mon_done;
  logic [2:0]   mon_err;
  logic         shadow_unused;

  assign mr_sel = mode_reg[MR_W-1:SEL_LSB];

  // Only the highest-priority strobe is encoded; DES and idle cycles both
  // deselect the device.
  always_comb begin
    cmd_d = CMD_NOP;
    if (mrs_rdy)
      cmd_d = CMD_MRS;
    else if (zqcl_rdy)
      cmd_d = CMD_ZQCL;
    else if (des_rdy)
      cmd_d = CMD_DES;
  end

  assign proto_d = (mrs_rdy & zqcl_rdy) | (mrs_rdy & des_rdy) | (zqcl_rdy & des_rdy);

  always_ff @(posedge CK_t) begin
    if (reset) begin
      bus_q       <= BUS_RESET;
      mr_loaded_q <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < 7; i++)
        mr_q[i] <= '0;
    end else begin
      bus_q <= encode_cmd(cmd_d, mr_sel, mode_reg[13:0]);
      if (proto_d)
        proto_err_q <= 1'b1;
      // MR7 (RFU) still goes out on the bus but has no shadow.
      if (cmd_d == CMD_MRS) begin
        for (int i = 0; i < 7; i++) begin
          if (mr_sel == 3'(i)) begin
            mr_q[i]        <= mode_reg[17:0];
            mr_loaded_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  ddr_timing_mon #(
    .TMRD (TMRD),
    .TMOD (TMOD),
    .TZQ  (TZQ)
  ) u_mon (
    .clk_i        (CK_t),
    .rst_i        (reset),
    .cmd_i        (cmd_d),
    .ini_done_i   (ini_done),
    .done_o       (mon_done),
    .timing_err_o (mon_err)
  );

  assign CS_n      = bus_q.cs_n;
  assign ACT_n     = bus_q.act_n;
  assign RAS_n_A16 = bus_q.ras_n;
  assign CAS_n_A15 = bus_q.cas_n;
  assign WE_n_A14  = bus_q.we_n;
  assign BG        = bus_q.bg;
  assign BA        = bus_q.ba;
  assign A         = bus_q.a;

  assign mr_loaded = mr_loaded_q;
  assign cl_code   = {mr_q[0][6:4], mr_q[0][2]};
  assign bl_code   = mr_q[0][1:0];
  assign al_code   = mr_q[1][4:3];
  assign cwl_code  = mr_q[2][5:3];
  assign wr_pre    = mr_q[4][12];
  assign rd_pre    = mr_q[4][11];

  // Full shadows are kept for future field decodes; fold the rest here.
  assign shadow_unused = ^{mr_q[0], mr_q[1], mr_q[2], mr_q[3], mr_q[4], mr_q[5], mr_q[6]};

  assign timing_err = mon_err;
  assign proto_err  = proto_err_q;
  assign init_ok    = mon_done && (mr_loaded_q == 7'h7F) && (mon_err == 3'b000) && !proto_err_q;

endmodule

// File: tb/tb_ddr_cmd_encoder.sv
// ---------------------------------------------------------------------------
// tb_ddr_cmd_encoder
// Directed bring-up scenarios plus randomized strobes, checked every cycle
// against an event-based reference model of the encoder and its monitor.
// ---------------------------------------------------------------------------
module tb_ddr_cmd_encoder;

  localparam int TMRD = 8;
  localparam int TMOD = 24;
  localparam int TZQ  = 1024;

  logic        CK_t = 1'b0;
  logic        rst = 1'b1;
  logic        des = 1'b0, mrs = 1'b0, zq = 1'b0, ini = 1'b0;
  logic [20:0] mr = '0;

  logic        CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  BG, BA;
  logic [13:0] A;
  logic [6:0]  mr_loaded;
  logic [3:0]  cl_code;
  logic [1:0]  bl_code, al_code;
  logic [2:0]  cwl_code;
  logic        wr_pre, rd_pre;
  logic [2:0]  timing_err;
  logic        proto_err, init_ok;

  int total = 0;
  int bad   = 0;

  always #5 CK_t = ~CK_t;

  ddr_cmd_encoder #(.MR_W(21), .TMRD(TMRD), .TMOD(TMOD), .TZQ(TZQ)) dut (
    .CK_t(CK_t), .reset(rst), .des_rdy(des), .mrs_rdy(mrs), .zqcl_rdy(zq),
    .mode_reg(mr), .ini_done(ini),
    .CS_n(CS_n), .ACT_n(ACT_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15),
    .WE_n_A14(WE_n_A14), .BG(BG), .BA(BA), .A(A),
    .mr_loaded(mr_loaded), .cl_code(cl_code), .bl_code(bl_code),
    .al_code(al_code), .cwl_code(cwl_code), .wr_pre(wr_pre), .rd_pre(rd_pre),
    .timing_err(timing_err), .proto_err(proto_err), .init_ok(init_ok)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the history of the bring-up as events: when the last MRS/ZQCL
  // happened, whether any MRS was seen, whether ZQCL was issued, and
  // whether the sequencer declared completion.
  int unsigned cyc = 0, last_cmd = 0;
  bit          m_en = 0, seen_mrs = 0, zq_issued = 0, finished = 0;
  logic [17:0] sh [7];
  logic [6:0]  ld;
  logic        e_tmrd, e_tmod, e_tzq, e_proto;
  logic        e_cs, e_care;
  logic [3:0]  e_ctl;
  logic [1:0]  e_bg, e_ba;
  logic [13:0] e_a;

  always @(posedge CK_t) begin : model
    int gap;
    int sel;
    cyc++;
    if (rst) begin
      m_en = 1; seen_mrs = 0; zq_issued = 0; finished = 0;
      last_cmd = cyc;
      for (int i = 0; i < 7; i++) sh[i] = '0;
      ld = '0; e_tmrd = 0; e_tmod = 0; e_tzq = 0; e_proto = 0;
      e_cs = 1; e_care = 1; e_ctl = 4'b1111; e_bg = 0; e_ba = 0; e_a = 0;
    end else if (m_en) begin
      gap = int'(cyc - last_cmd) - 1;
      sel = int'(mr[20:18]);
      e_cs = 1; e_care = 0; e_ctl = 4'b0000; e_bg = 0; e_ba = 0; e_a = 0;
      if (int'(mrs) + int'(zq) + int'(des) > 1) e_proto = 1;
      if (mrs) begin
        e_cs = 0; e_care = 1; e_ctl = 4'b1000;
        e_bg = {1'b0, mr[20]}; e_ba = mr[19:18]; e_a = mr[13:0];
        if (sel < 7) begin sh[sel] = mr[17:0]; ld[sel] = 1'b1; end
      end else if (zq) begin
        e_cs = 0; e_care = 1; e_ctl = 4'b1110; e_a = 14'h0400;
      end
      if (!finished) begin
        if (!seen_mrs) begin
          if (ini) begin finished = 1; e_tmod = 1; end
          else if (mrs) seen_mrs = 1;
        end else if (!zq_issued) begin
          if (mrs && gap < TMRD - 1) e_tmrd = 1;
          if (!mrs && zq && gap < TMOD - 1) e_tmod = 1;
          if (ini) begin finished = 1; e_tmod = 1; end
          else if (!mrs && zq) zq_issued = 1;
        end else begin
          if ((mrs || zq) && gap < TZQ - 1) e_tzq = 1;
          if (ini) finished = 1;
        end
      end
      if (mrs || zq) last_cmd = cyc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CK_t) begin
    if (m_en) begin
      chk("cs_n", CS_n, e_cs);
      if (e_care) chk("ctl", {ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, e_ctl);
      chk("addr", {BG, BA, A}, {e_bg, e_ba, e_a});
      chk("mr_loaded", mr_loaded, ld);
      chk("decode", {cl_code, bl_code, al_code, cwl_code, wr_pre, rd_pre},
          {sh[0][6:4], sh[0][2], sh[0][1:0], sh[1][4:3], sh[2][5:3], sh[4][12], sh[4][11]});
      chk("errors", {timing_err, proto_err}, {e_tzq, e_tmod, e_tmrd, e_proto});
      chk("init_ok", init_ok,
          finished && ld == 7'h7F && !e_tmrd && !e_tmod && !e_tzq && !e_proto);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic m, input logic z, input logic d, input logic i,
                      input logic [20:0] v);
    mrs = m; zq = z; des = d; ini = i; mr = v;
    @(negedge CK_t);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1'($urandom_range(0, 1)), 0, 21'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 21'($urandom));
    rst = 0;
  endtask

  task automatic mr_burst(input int n, input bit short_gap);
    int order [7] = '{3, 6, 5, 4, 2, 1, 0};
    for (int k = 0; k < n; k++) begin
      step(1, 0, 0, 0, {3'(order[k]), 18'($urandom)});
      if (k < 6) idle((short_gap && k == 0) ? 2 : TMRD - 1);
    end
  endtask

  task automatic finish_seq();
    idle(TMOD - 1);
    step(0, 1, 0, 0, '0);
    for (int k = 0; k < TZQ; k++) step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, '0);
  endtask

  initial begin
    logic [20:0] v;
    do_reset(3);
    step(0, 0, 0, 0, '0);
    chk("rst_cs_n", CS_n, 1'b1);
    chk("rst_init_ok", init_ok, 1'b0);
    chk("rst_loaded", mr_loaded, 7'h00);
    chk("rst_terr", timing_err, 3'b000);

    // single MR0 write
    v = {3'b000, 18'h00D34};
    step(1, 0, 0, 0, v);
    chk("mrs_cs", CS_n, 1'b0);
    chk("mrs_ctl", {ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 4'b1000);
    chk("mrs_ba", BA, 2'b00);
    chk("mrs_a", A, 14'h0D34);
    chk("mrs_cl", cl_code, 4'h7);
    chk("mrs_bl", bl_code, 2'b00);
    chk("mrs_loaded", mr_loaded, 7'h01);
    idle(3);

    // full legal bring-up
    do_reset(1);
    mr_burst(7, 0);
    finish_seq();
    chk("legal_init_ok", init_ok, 1'b1);
    chk("legal_terr", timing_err, 3'b000);
    idle(4);

    // tMRD violation
    do_reset(2);
    mr_burst(7, 1);
    finish_seq();
    chk("tmrd_terr", timing_err, 3'b001);
    chk("tmrd_init_ok", init_ok, 1'b0);

    // simultaneous strobes
    do_reset(1);
    step(1, 1, 0, 0, {3'b001, 18'h00018});
    chk("both_cs", CS_n, 1'b0);
    chk("both_ctl", {ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 4'b1000);
    chk("both_proto", proto_err, 1'b1);
    chk("both_al", al_code, 2'b11);

    // MR7 is encoded but not shadowed
    do_reset(1);
    step(1, 0, 0, 0, {3'b111, 18'h3FFFF});
    chk("mr7_bgba", {BG, BA}, 4'b0111);
    chk("mr7_a", A, 14'h3FFF);
    chk("mr7_loaded", mr_loaded, 7'h00);

    // reset between MR4 and MR2, then restart
    do_reset(1);
    mr_burst(4, 0);
    idle(TMRD - 1);
    do_reset(1);
    chk("mid_rst_loaded", mr_loaded, 7'h00);
    mr_burst(7, 0);
    finish_seq();
    chk("restart_init_ok", init_ok, 1'b1);

    // randomized strobes
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset(1);
      else begin
        r = $urandom_range(0, 99);
        step(r < 8 || r == 99, (r >= 8 && r < 12) || r == 98,
             (r >= 12 && r < 40) || r == 97, $urandom_range(0, 99) == 0,
             21'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
